// File: rtl/div_unit_pkg.sv
// div_unit_pkg: state encoding and result-bus width for the iterative divider
package div_unit_pkg;
  typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_e;
  localparam int DIV_RESULT_BUS = 64;
endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring DIV/DIVU with stall request, annul and one-cycle ready pulse
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  div_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvs, rem, quo, rem_nx, quo_nx, a_abs, b_abs;
  logic [WIDTH:0] shifted, diff;
  logic neg_q, neg_r, armed, accept;
  always_comb begin
    accept = state == DIV_FREE && start_i && !annul_i && armed;
    a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    shifted = {rem, quo[WIDTH-1]};
    diff = shifted - {1'b0, dvs};
    rem_nx = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};
    stallreq_o = accept || state == DIV_ON || state == DIV_BY_ZERO;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_FREE;
      cnt <= '0;
      result_o <= '0;
      ready_o <= 1'b0;
      armed <= 1'b1;
    end else begin
      ready_o <= 1'b0;
      if (!start_i) armed <= 1'b1;
      if (annul_i) state <= DIV_FREE;
      else case (state)
        DIV_FREE: if (accept) begin
          armed <= 1'b0;
          cnt <= '0;
          rem <= '0;
          if (opdata2_i == '0) begin
            quo <= opdata1_i;
            state <= DIV_BY_ZERO;
          end else begin
            quo <= a_abs;
            dvs <= b_abs;
            neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r <= signed_div_i && opdata1_i[WIDTH-1];
            state <= DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          result_o <= {quo, {WIDTH{1'b1}}};
          ready_o <= 1'b1;
          state <= DIV_END;
        end
        DIV_ON: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result_o <= {neg_r ? -rem_nx : rem_nx, neg_q ? -quo_nx : quo_nx};
            ready_o <= 1'b1;
            state <= DIV_END;
          end
        end
        DIV_END: state <= DIV_FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and randomized checks of div_unit against an arithmetic model
module tb_div_unit;
  logic clk = 0, rst = 1, start_i = 0, signed_div_i = 0, annul_i = 0;
  logic [31:0] opdata1_i = 0, opdata2_i = 0;
  logic [63:0] result_o;
  logic ready_o, stallreq_o;
  int n_pass = 0, n_total = 0;
  typedef struct { logic s; logic [31:0] a; logic [31:0] b; logic [63:0] exp; } vec_t;
  vec_t vecs[7];
  div_unit dut (.clk(clk), .rst(rst), .start_i(start_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o));
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_div(logic s, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFFFFFF};
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input logic scramble,
                        output logic [63:0] res, output int lat, output int stl);
    start_i = 1; signed_div_i = s; opdata1_i = a; opdata2_i = b;
    lat = 0; stl = 0;
    while (!ready_o && lat < 100) begin
      #1;
      if (stallreq_o) stl++;
      @(negedge clk);
      lat++;
      if (scramble && lat == 5) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
      end
    end
    res = result_o;
  endtask
  task automatic idle_watch(input int n, output int readies);
    readies = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready_o) readies++;
    end
  endtask
  initial begin
    logic [63:0] res, prev;
    int lat, stl, rdy;
    vecs[0] = '{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2] = '{1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'd1, {32'h00000000, 32'hFFFFFFFF}};
    vecs[5] = '{1'b0, 32'h00001234, 32'd0, {32'h00001234, 32'hFFFFFFFF}};
    vecs[6] = '{1'b1, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF}};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_result", result_o, 0);
    check("reset_ready", 64'(ready_o), 0);
    check("reset_stall", 64'(stallreq_o), 0);
    for (int i = 0; i < 7; i++) begin
      do_div(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, res, lat, stl);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].b == 0 ? 2 : 33);
      check($sformatf("vec%0d_stall_cycles", i), 64'(stl), vecs[i].b == 0 ? 2 : 33);
      check($sformatf("vec%0d_stall_done", i), 64'(stallreq_o), 0);
      start_i = 0;
      @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom);
      a = $urandom;
      b = (i % 8 == 0) ? 0 : (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom >> $urandom_range(0, 31);
      do_div(s, a, b, 1'b1, res, lat, stl);
      check($sformatf("rand%0d_result", i), res, ref_div(s, a, b));
      check($sformatf("rand%0d_latency", i), 64'(lat), b == 0 ? 2 : 33);
      start_i = 0;
      @(negedge clk);
    end
    start_i = 1; annul_i = 1; signed_div_i = 0; opdata1_i = 100; opdata2_i = 7;
    #1 check("annul_prio_stall", 64'(stallreq_o), 0);
    @(negedge clk);
    check("annul_prio_idle_stall", 64'(stallreq_o), 0);
    check("annul_prio_ready", 64'(ready_o), 0);
    start_i = 0; annul_i = 0;
    @(negedge clk);
    prev = result_o;
    start_i = 1; opdata1_i = 1000; opdata2_i = 3;
    repeat (11) @(negedge clk);
    annul_i = 1; start_i = 0;
    @(negedge clk);
    annul_i = 0;
    #1 check("annul_stall_low", 64'(stallreq_o), 0);
    check("annul_ready_low", 64'(ready_o), 0);
    idle_watch(40, rdy);
    check("annul_no_ready", 64'(rdy), 0);
    check("annul_result_kept", result_o, prev);
    start_i = 1; opdata1_i = 1000; opdata2_i = 3;
    repeat (21) @(negedge clk);
    rst = 1; start_i = 0;
    @(negedge clk);
    rst = 0;
    check("rst_mid_result", result_o, 0);
    check("rst_mid_ready", 64'(ready_o), 0);
    idle_watch(40, rdy);
    check("rst_mid_no_ready", 64'(rdy), 0);
    do_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat, stl);
    check("after_rst_result", res, {32'd0, 32'd3});
    check("after_rst_latency", 64'(lat), 33);
    start_i = 0;
    @(negedge clk);
    do_div(1'b0, 32'd100, 32'd7, 1'b0, res, lat, stl);
    check("b2b_first", res, {32'd2, 32'd14});
    rdy = 0; stl = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (ready_o) rdy++;
      if (stallreq_o) stl++;
    end
    check("b2b_held_no_ready", 64'(rdy), 0);
    check("b2b_held_no_stall", 64'(stl), 0);
    start_i = 0;
    @(negedge clk);
    do_div(1'b0, 32'd50, 32'd5, 1'b0, res, lat, stl);
    check("b2b_second", res, {32'd0, 32'd10});
    check("b2b_second_latency", 64'(lat), 33);
    start_i = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
